program_loader: RTL and testbench
=================================

Name: program_loader

Overview:
- Upstream feeder of the instruction-fetch stage.
- Accepts a byte stream from the debug UART receiver and assembles the bytes into 32-bit MIPS instruction words.
- Drives the fetch stage's instruction-memory write port: write enable, byte address and data.
- Stops at the HALT word. While loading, it raises o_loading so the pipeline is held stalled/halted.

Parameters:
MEM_BYTES, 4096, instruction memory size in bytes (4K, word-aligned); MAX_WORDS = MEM_BYTES/4
HALT_WORD, 32'hFFFFFFFF, instruction word that terminates a program image

Ports:
i_clk  in  1  clock; all logic on rising edge
i_reset_n  in  1  synchronous, active-low reset
i_start  in  1  single-cycle request to begin a new program load
i_rx_data  in  8  received byte from UART
i_rx_valid  in  1  one-cycle strobe; i_rx_data valid this cycle
o_write_instruction_mem  out  1  write strobe to fetch-stage instruction memory
o_instruction_mem_addr  out  32  byte address of the word being written (word index * 4)
o_instruction_mem_data  out  32  assembled instruction word
o_loading  out  1  high while a load is in progress (RECEIVE or WRITE)
o_done  out  1  held high after HALT_WORD is written
o_error  out  1  held high if memory fills before HALT_WORD
o_word_count  out  11  words written in the current/last load, HALT word included

Behaviour:
- Reset (i_reset_n low at a clock edge): state=IDLE; all outputs 0; internal byte counter, assembly register and word index cleared.
  - Reset mid-load aborts the load immediately. No write strobe is issued on or after that edge.
- Byte order: big-endian. The first byte received becomes bits [31:24]; assembly is word <= {word[23:0], byte}.
- FSM states:
  - IDLE: o_loading=0. i_rx_valid ignored. i_start -> RECEIVE; clears word index, o_word_count, byte counter, o_done, o_error.
  - RECEIVE: o_loading=1. Each i_rx_valid shifts a byte in and increments the 2-bit byte counter. On the 4th byte -> WRITE. i_start ignored.
  - WRITE: exactly one cycle.
    - o_write_instruction_mem=1, o_instruction_mem_addr=word_index*4, o_instruction_mem_data=assembled word (both registered, stable for the strobe cycle).
    - o_word_count increments at the end of this cycle.
    - Next state: word==HALT_WORD -> DONE; else word_index==MAX_WORDS-1 -> ERROR; else word_index+1 -> RECEIVE.
  - DONE: o_done=1, o_loading=0. Bytes ignored. i_start -> RECEIVE (fresh load, o_done cleared).
  - ERROR: o_error=1, o_loading=0. Bytes ignored. i_start -> RECEIVE (o_error cleared).
- Latency: the write strobe is asserted in the cycle immediately after the edge that accepted the 4th byte.
- Byte arriving during WRITE (back-to-back stream):
  - If the transition is to RECEIVE, the byte is captured as byte 0 of the next word; byte counter becomes 1. No byte is ever dropped.
  - If the transition is to DONE or ERROR, the byte is discarded.
- Partial word (1-3 bytes) at any time: never written. It persists until completed, i_start in DONE/ERROR, or reset.
- Address never exceeds MEM_BYTES-4. There is no wrap-around: ERROR is entered instead.
- o_write_instruction_mem is 0 in every state except WRITE.
- Outside WRITE, address/data hold their last values; they are only meaningful while the strobe is high.
- o_loading and o_write are mutually consistent: o_write=1 implies o_loading=1.

Test Plan:
1. Reset then i_start, bytes 20 08 00 05 FF FF FF FF (one per 3 cycles).
   - Required: write #1 addr 0x0 data 0x20080005; write #2 addr 0x4 data 0xFFFFFFFF; then o_done=1, o_loading=0, o_word_count=2.
2. Back-to-back bytes every cycle (valid also in the WRITE cycle): 8 bytes 00 00 00 01 00 00 00 02 followed by FF FF FF FF.
   - Required: 3 writes with data 0x00000001, 0x00000002, 0xFFFFFFFF at addrs 0x0, 0x4, 0x8; no byte lost.
3. Bytes before i_start, and bytes after DONE.
   - Required: no write strobe; o_loading stays 0.
4. Stream MAX_WORDS non-halt words (MEM_BYTES=64 override, 16 words of 0x00000000).
   - Required: last write at addr 0x3C, then o_error=1, o_word_count=16; further bytes ignored.
5. i_reset_n low after 2 bytes of the 2nd word.
   - Required: next cycle all outputs 0, state IDLE. New i_start + 4 bytes writes to addr 0x0 with the new data only.
6. i_start in DONE after scenario 1, then AA BB CC DD FF FF FF FF.
   - Required: o_done drops; write 0xAABBCCDD at 0x0; o_word_count restarts at 1 then 2.

Source files
------------

// File: rtl/program_loader_if.sv
// Byte-stream input and instruction-memory write port of the program loader.
// Grouped so the loader and its driver share one connection point.
interface program_loader_if;
    logic        i_start;
    logic [7:0]  i_rx_data;
    logic        i_rx_valid;
    logic        o_write_instruction_mem;
    logic [31:0] o_instruction_mem_addr;
    logic [31:0] o_instruction_mem_data;
    logic        o_loading;
    logic        o_done;
    logic        o_error;
    logic [10:0] o_word_count;

    modport master (
        output i_start, i_rx_data, i_rx_valid,
        input  o_write_instruction_mem, o_instruction_mem_addr, o_instruction_mem_data,
        input  o_loading, o_done, o_error, o_word_count
    );

    modport slave (
        input  i_start, i_rx_data, i_rx_valid,
        output o_write_instruction_mem, o_instruction_mem_addr, o_instruction_mem_data,
        output o_loading, o_done, o_error, o_word_count
    );
endinterface

// File: rtl/program_loader.sv
// Assembles big-endian UART bytes into 32-bit words and writes them to instruction memory until HALT_WORD.
// Latency: write strobe one cycle after the edge accepting the 4th byte of a word.
// Backpressure: none; a byte arriving in the write cycle is kept for the next word, never dropped.
module program_loader #(
    parameter int          MEM_BYTES = 4096,
    parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
    input  logic i_clk,
    input  logic i_reset_n,
    program_loader_if.slave bus
);
    localparam int MAX_WORDS = MEM_BYTES / 4;
    localparam int IDX_W     = $clog2(MAX_WORDS);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RECEIVE,
        ST_WRITE,
        ST_DONE,
        ST_ERROR
    } state_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] dat;
    } imem_wr_t;

    state_t           state_q;
    state_t           state_nxt;
    logic [1:0]       byte_cnt_q;
    logic [31:0]      word_q;
    logic [IDX_W-1:0] word_idx_q;
    logic [10:0]      word_cnt_q;
    imem_wr_t         wr_q;

    logic             start_load;
    logic             accept_byte;
    logic             last_byte;
    logic             last_slot;
    logic [31:0]      word_shift;

    assign word_shift = {word_q[23:0], bus.i_rx_data};
    assign last_slot  = (word_idx_q == IDX_W'(MAX_WORDS - 1));

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state_q;
        start_load  = 1'b0;
        accept_byte = 1'b0;
        last_byte   = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (bus.i_start) begin
                    start_load = 1'b1;
                    state_nxt  = ST_RECEIVE;
                end
            end
            ST_RECEIVE: begin
                if (bus.i_rx_valid) begin
                    accept_byte = 1'b1;
                    if (byte_cnt_q == 2'd3) begin
                        last_byte = 1'b1;
                        state_nxt = ST_WRITE;
                    end
                end
            end
            ST_WRITE: begin
                // A byte landing here only survives if another word follows.
                if (wr_q.dat == HALT_WORD) begin
                    state_nxt = ST_DONE;
                end else if (last_slot) begin
                    state_nxt = ST_ERROR;
                end else begin
                    state_nxt   = ST_RECEIVE;
                    accept_byte = bus.i_rx_valid;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            byte_cnt_q <= '0;
            word_q     <= '0;
            word_idx_q <= '0;
            word_cnt_q <= '0;
            wr_q       <= '0;
        end else begin
            if (start_load) begin
                byte_cnt_q <= '0;
                word_idx_q <= '0;
                word_cnt_q <= '0;
            end
            if (accept_byte) begin
                word_q     <= word_shift;
                byte_cnt_q <= byte_cnt_q + 2'd1;
            end
            if (last_byte) begin
                wr_q.addr <= {{(30 - IDX_W){1'b0}}, word_idx_q, 2'b00};
                wr_q.dat  <= word_shift;
            end
            if (state_q == ST_WRITE) begin
                word_cnt_q <= word_cnt_q + 11'd1;
                if (state_nxt == ST_RECEIVE) begin
                    word_idx_q <= word_idx_q + IDX_W'(1);
                end
            end
        end
    end

    assign bus.o_write_instruction_mem = (state_q == ST_WRITE);
    assign bus.o_instruction_mem_addr  = wr_q.addr;
    assign bus.o_instruction_mem_data  = wr_q.dat;
    assign bus.o_loading               = (state_q == ST_RECEIVE) || (state_q == ST_WRITE);
    assign bus.o_done                  = (state_q == ST_DONE);
    assign bus.o_error                 = (state_q == ST_ERROR);
    assign bus.o_word_count            = word_cnt_q;
endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: per-cycle vector table plus hand-written load sequences.
module tb_program_loader;
    logic clk;
    logic rst_a_n;
    logic rst_b_n;

    program_loader_if ifa ();
    program_loader_if ifb ();

    program_loader dut_a (
        .i_clk     (clk),
        .i_reset_n (rst_a_n),
        .bus       (ifa.slave)
    );

    program_loader #(.MEM_BYTES(64)) dut_b (
        .i_clk     (clk),
        .i_reset_n (rst_b_n),
        .bus       (ifb.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        rst_n;
        logic        start;
        logic        vld;
        logic [7:0]  dat;
        logic        chk_ad;
        logic        e_wr;
        logic [31:0] e_addr;
        logic [31:0] e_data;
        logic        e_ld;
        logic        e_dn;
        logic        e_er;
        logic [10:0] e_cnt;
    } vec_t;

    vec_t vt[$];

    logic [63:0] wa_q[$];
    int          wb_n   = 0;
    int          wb_bad = 0;
    logic [31:0] wb_last = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic r, s, v, input logic [7:0] d, input logic ca, w,
                       input logic [31:0] a, dt, input logic l, dn, er, input logic [10:0] c);
        vec_t x;
        x.rst_n = r; x.start = s; x.vld = v; x.dat = d; x.chk_ad = ca | w; x.e_wr = w;
        x.e_addr = a; x.e_data = dt; x.e_ld = l; x.e_dn = dn; x.e_er = er; x.e_cnt = c;
        vt.push_back(x);
    endtask

    always @(negedge clk) begin
        if (ifa.o_write_instruction_mem) begin
            wa_q.push_back({ifa.o_instruction_mem_addr, ifa.o_instruction_mem_data});
            chk("wr_implies_loading", 32'(ifa.o_loading), 32'd1);
        end
        if (ifb.o_write_instruction_mem) begin
            if (ifb.o_instruction_mem_addr !== 32'(wb_n * 4) || ifb.o_instruction_mem_data !== 32'h0)
                wb_bad++;
            wb_last = ifb.o_instruction_mem_addr;
            wb_n++;
        end
    end

    initial begin
        logic [7:0] prog1[8];
        prog1 = '{8'h20, 8'h08, 8'h00, 8'h05, 8'hFF, 8'hFF, 8'hFF, 8'hFF};

        // Restart from DONE with a new image.
        add(1,0,1,8'h11, 0,0,0,0,            0,1,0,2);
        add(1,1,0,8'h00, 0,0,0,0,            1,0,0,0);
        add(1,0,1,8'hAA, 0,0,0,0,            1,0,0,0);
        add(1,0,1,8'hBB, 0,0,0,0,            1,0,0,0);
        add(1,0,1,8'hCC, 0,0,0,0,            1,0,0,0);
        add(1,0,1,8'hDD, 0,1,0,32'hAABBCCDD, 1,0,0,0);
        add(1,0,0,8'h00, 0,0,0,0,            1,0,0,1);
        add(1,0,1,8'hFF, 0,0,0,0,            1,0,0,1);
        add(1,0,1,8'hFF, 0,0,0,0,            1,0,0,1);
        add(1,0,1,8'hFF, 0,0,0,0,            1,0,0,1);
        add(1,0,1,8'hFF, 0,1,4,32'hFFFFFFFF, 1,0,0,1);
        add(1,0,0,8'h00, 0,0,0,0,            0,1,0,2);
        // Reset after two bytes of the second word, then a fresh load.
        add(1,1,0,8'h00, 0,0,0,0,            1,0,0,0);
        add(1,0,1,8'h12, 0,0,0,0,            1,0,0,0);
        add(1,0,1,8'h34, 0,0,0,0,            1,0,0,0);
        add(1,0,1,8'h56, 0,0,0,0,            1,0,0,0);
        add(1,0,1,8'h78, 0,1,0,32'h12345678, 1,0,0,0);
        add(1,0,1,8'h9A, 0,0,0,0,            1,0,0,1);
        add(1,0,1,8'hBC, 0,0,0,0,            1,0,0,1);
        add(0,0,1,8'hDE, 1,0,0,0,            0,0,0,0);
        add(1,0,1,8'hF0, 0,0,0,0,            0,0,0,0);
        add(1,1,0,8'h00, 0,0,0,0,            1,0,0,0);
        add(1,0,1,8'h01, 0,0,0,0,            1,0,0,0);
        add(1,0,1,8'h02, 0,0,0,0,            1,0,0,0);
        add(1,0,1,8'h03, 0,0,0,0,            1,0,0,0);
        add(1,0,1,8'h04, 0,1,0,32'h01020304, 1,0,0,0);
        add(1,0,0,8'h00, 0,0,0,0,            1,0,0,1);
        // Bytes before start, then a back-to-back stream including the write cycles.
        add(0,0,0,8'h00, 1,0,0,0,            0,0,0,0);
        add(1,0,1,8'h55, 0,0,0,0,            0,0,0,0);
        add(1,1,1,8'h66, 0,0,0,0,            1,0,0,0);
        add(1,0,1,8'h00, 0,0,0,0,            1,0,0,0);
        add(1,0,1,8'h00, 0,0,0,0,            1,0,0,0);
        add(1,0,1,8'h00, 0,0,0,0,            1,0,0,0);
        add(1,0,1,8'h01, 0,1,0,32'h00000001, 1,0,0,0);
        add(1,0,1,8'h00, 0,0,0,0,            1,0,0,1);
        add(1,0,1,8'h00, 0,0,0,0,            1,0,0,1);
        add(1,0,1,8'h00, 0,0,0,0,            1,0,0,1);
        add(1,0,1,8'h02, 0,1,4,32'h00000002, 1,0,0,1);
        add(1,0,1,8'hFF, 0,0,0,0,            1,0,0,2);
        add(1,0,1,8'hFF, 0,0,0,0,            1,0,0,2);
        add(1,0,1,8'hFF, 0,0,0,0,            1,0,0,2);
        add(1,0,1,8'hFF, 0,1,8,32'hFFFFFFFF, 1,0,0,2);
        add(1,0,1,8'hFF, 0,0,0,0,            0,1,0,3);
        add(1,0,1,8'hFF, 0,0,0,0,            0,1,0,3);
        add(1,0,0,8'h00, 0,0,0,0,            0,1,0,3);

        rst_a_n = 1'b0; rst_b_n = 1'b0;
        ifa.i_start = 1'b0; ifa.i_rx_valid = 1'b0; ifa.i_rx_data = '0;
        ifb.i_start = 1'b0; ifb.i_rx_valid = 1'b0; ifb.i_rx_data = '0;
        step(); step();

        chk("rst_wr",   32'(ifa.o_write_instruction_mem), 32'd0);
        chk("rst_addr", ifa.o_instruction_mem_addr,       32'd0);
        chk("rst_data", ifa.o_instruction_mem_data,       32'd0);
        chk("rst_ld",   32'(ifa.o_loading),               32'd0);
        chk("rst_done", 32'(ifa.o_done),                  32'd0);
        chk("rst_err",  32'(ifa.o_error),                 32'd0);
        chk("rst_cnt",  32'(ifa.o_word_count),            32'd0);

        // Two-word program, one byte every three cycles.
        rst_a_n = 1'b1;
        step();
        wa_q.delete();
        ifa.i_start = 1'b1; step(); ifa.i_start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            ifa.i_rx_valid = 1'b1; ifa.i_rx_data = prog1[i];
            step();
            ifa.i_rx_valid = 1'b0;
            step(); step();
        end
        for (int k = 0; k < 20 && !ifa.o_done; k++) step();
        chk("s1_done",   32'(ifa.o_done),       32'd1);
        chk("s1_ld",     32'(ifa.o_loading),    32'd0);
        chk("s1_cnt",    32'(ifa.o_word_count), 32'd2);
        chk("s1_nwr",    32'(wa_q.size()),      32'd2);
        if (wa_q.size() >= 2) begin
            chk("s1_w0_addr", wa_q[0][63:32], 32'h0);
            chk("s1_w0_data", wa_q[0][31:0],  32'h20080005);
            chk("s1_w1_addr", wa_q[1][63:32], 32'h4);
            chk("s1_w1_data", wa_q[1][31:0],  32'hFFFFFFFF);
        end

        foreach (vt[i]) begin
            rst_a_n = vt[i].rst_n;
            ifa.i_start = vt[i].start;
            ifa.i_rx_valid = vt[i].vld;
            ifa.i_rx_data = vt[i].dat;
            step();
            chk($sformatf("v%0d_wr", i),   32'(ifa.o_write_instruction_mem), 32'(vt[i].e_wr));
            chk($sformatf("v%0d_ld", i),   32'(ifa.o_loading),               32'(vt[i].e_ld));
            chk($sformatf("v%0d_done", i), 32'(ifa.o_done),                  32'(vt[i].e_dn));
            chk($sformatf("v%0d_err", i),  32'(ifa.o_error),                 32'(vt[i].e_er));
            chk($sformatf("v%0d_cnt", i),  32'(ifa.o_word_count),            32'(vt[i].e_cnt));
            if (vt[i].chk_ad) begin
                chk($sformatf("v%0d_addr", i), ifa.o_instruction_mem_addr, vt[i].e_addr);
                chk($sformatf("v%0d_data", i), ifa.o_instruction_mem_data, vt[i].e_data);
            end
        end
        rst_a_n = 1'b1; ifa.i_start = 1'b0; ifa.i_rx_valid = 1'b0;

        // Fill a 16-word memory with non-halt words.
        rst_b_n = 1'b1;
        step();
        ifb.i_start = 1'b1; step(); ifb.i_start = 1'b0;
        for (int i = 0; i < 64; i++) begin
            ifb.i_rx_valid = 1'b1; ifb.i_rx_data = 8'h00;
            step();
        end
        ifb.i_rx_valid = 1'b0;
        for (int k = 0; k < 10 && !ifb.o_error; k++) step();
        chk("s4_err",    32'(ifb.o_error),      32'd1);
        chk("s4_done",   32'(ifb.o_done),       32'd0);
        chk("s4_ld",     32'(ifb.o_loading),    32'd0);
        chk("s4_cnt",    32'(ifb.o_word_count), 32'd16);
        chk("s4_nwr",    32'(wb_n),             32'd16);
        chk("s4_last",   wb_last,               32'h3C);
        chk("s4_order",  32'(wb_bad),           32'd0);
        for (int i = 0; i < 4; i++) begin
            ifb.i_rx_valid = 1'b1; ifb.i_rx_data = 8'h00;
            step();
        end
        ifb.i_rx_valid = 1'b0;
        step(); step();
        chk("s4_post_nwr", 32'(wb_n),             32'd16);
        chk("s4_post_err", 32'(ifb.o_error),      32'd1);
        chk("s4_post_cnt", 32'(ifb.o_word_count), 32'd16);
        ifb.i_start = 1'b1; step(); ifb.i_start = 1'b0;
        chk("s4_restart_err", 32'(ifb.o_error),      32'd0);
        chk("s4_restart_ld",  32'(ifb.o_loading),    32'd1);
        chk("s4_restart_cnt", 32'(ifb.o_word_count), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
